logs_split: RTL and testbench
=============================

// Module: logs_split
// PURPOSE
//  Sequential inverse of the tree adder: takes a scalar total and distributes it into
//  NADDENDS packed NBITS-wide slots so the slots sum back to the total. Used to refill
//  per-slot counters from a single budget value. Start/busy/done handshake, one clock.
// PARAMETERS
//  NBITS     3  width of each output slot; slot capacity MAX = 2**NBITS-1
//  NADDENDS  6  number of output slots (>=1)
//  TBITS     6  width of the input total
// PORTS
//  clk       in   1                 clock, all state on rising edge
//  rst       in   1                 synchronous, active-high reset
//  start     in   1                 request; sampled only in IDLE
//  total     in   TBITS             value to distribute; latched when start accepted
//  busy      out  1                 high from cycle after accepted start until done cycle inclusive
//  done      out  1                 one-cycle pulse: parts/overflow final
//  overflow  out  1                 total exceeded NADDENDS*MAX; valid from done until next start
//  parts     out  [NADDENDS-1:0][NBITS-1:0]  distributed values, slot 0 = parts[0]
// BEHAVIOUR
//  - Reset: state=IDLE, parts=0, busy=0, done=0, overflow=0, rem=0, idx=0.
//  - Reset mid-operation: same values next cycle; operation abandoned, no done.
//  - States IDLE -> FILL -> DONE -> IDLE.
//  - IDLE: start=1 -> rem<=total, parts<=0, overflow<=0, idx<=0, go FILL. Else hold.
//  - FILL (greedy): each cycle take=min(rem,MAX); parts[idx]<=take; rem<=rem-take;
//    idx<=idx+1. Go DONE when rem-take==0 or idx==NADDENDS-1 (slot written that cycle).
//    total=0 still spends one FILL cycle writing parts[0]=0.
//  - DONE: done=1 for exactly one cycle; overflow<=(rem!=0); then IDLE.
//  - Latency: done high W+1 cycles after start sampled, W = slots written (1..NADDENDS).
//  - start while busy/DONE ignored (no queueing); start in the IDLE cycle after DONE accepted.
//  - parts/overflow hold after done until next accepted start or rst.
//  - Arithmetic: rem is TBITS wide, never underflows (take<=rem); take zero-extended
//    from NBITS; compare against MAX in TBITS width. Sum(parts)+final rem == total.
// CONFIGURATION
//  LOGS_SPLIT_EVEN_EN defined: FILL deals one unit per cycle round-robin over slots,
//    skipping full slots: parts[i] = floor(total/N) or +1 for the lowest (total mod N)
//    slots, capped at MAX. Exit to DONE when rem==0 or all slots full; W = units dealt
//    + skip cycles (total=0 -> one FILL cycle, no write). overflow as above.
//  Not defined: greedy fill as above; even-dealing logic absent.
// TESTING  (NBITS=3, NADDENDS=6, TBITS=6, MAX=7)
//  1 greedy total=17 start 1 cycle -> parts={0,0,0,3,7,7} (p5..p0), done 4 cycles after start, overflow=0
//  2 total=42 -> all slots 7, done 7 cycles after start, overflow=0; total=0 -> parts 0, done at +2
//  3 total=50 -> all slots 7, overflow=1 at done; next start total=5 clears overflow, parts[0]=5
//  4 start pulsed while busy with total=9 -> ignored, results of first request unchanged
//  5 rst asserted mid-FILL of total=30 -> next cycle parts=0, busy=0, no done pulse
//  6 EVEN_EN total=8 -> parts={1,1,1,1,2,2} (p5..p0), done 9 cycles after start, overflow=0

Source files
------------

// File: rtl/logs_split_if.sv
// logs_split_if: the start/busy/done handshake and result bus of logs_split.
//   master : requester side (drives start/total, observes results)
//   slave  : the splitter itself
//   start     request pulse, sampled only while the splitter is idle
//   total     value to distribute, latched when start is accepted
//   busy      operation in progress (FILL and DONE states)
//   done      one-cycle pulse, parts/overflow are final
//   overflow  total did not fit into NADDENDS full slots
//   parts     packed slot values, slot 0 = parts[0]
interface logs_split_if #(
  parameter int NBITS    = 3,
  parameter int NADDENDS = 6,
  parameter int TBITS    = 6
);
  logic                          start;
  logic [TBITS-1:0]              total;
  logic                          busy;
  logic                          done;
  logic                          overflow;
  logic [NADDENDS-1:0][NBITS-1:0] parts;

  modport master (output start, output total,
                  input  busy, input done, input overflow, input parts);
  modport slave  (input  start, input total,
                  output busy, output done, output overflow, output parts);
endinterface

// File: rtl/logs_split.sv
// logs_split: sequential splitter, the inverse of a tree adder. A scalar total
// is distributed over NADDENDS slots of NBITS each so the slots sum back to
// the total; whatever does not fit is flagged as overflow.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  logs_split_if.slave: start/total in, busy/done/overflow/parts out
// Build option: LOGS_SPLIT_EVEN_EN selects round-robin one-unit dealing
// (skipping full slots) instead of the default greedy fill.
module logs_split #(
  parameter int NBITS    = 3,
  parameter int NADDENDS = 6,
  parameter int TBITS    = 6
) (
  input logic         clk,
  input logic         rst,
  logs_split_if.slave bus
);

  localparam int IW = (NADDENDS > 1) ? $clog2(NADDENDS) : 1;
  localparam logic [TBITS-1:0] MAX_T   = TBITS'((1 << NBITS) - 1);
  localparam logic [IW-1:0]    LAST_IX = IW'(NADDENDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [TBITS-1:0]               rem_q, rem_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic [NADDENDS-1:0][NBITS-1:0] parts_q, parts_d;
  logic                           overflow_q, overflow_d;
  logic                           fill_exit;

`ifdef LOGS_SPLIT_EVEN_EN
  logic all_full;
`else
  logic [NBITS-1:0] take;
`endif

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    parts_d    = parts_q;
    overflow_d = overflow_q;
    fill_exit  = 1'b0;
`ifdef LOGS_SPLIT_EVEN_EN
    all_full   = 1'b1;
`else
    take       = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rem_d      = bus.total;
          parts_d    = '0;
          overflow_d = 1'b0;
          idx_d      = '0;
          state_d    = S_FILL;
        end
      end

      S_FILL: begin
`ifdef LOGS_SPLIT_EVEN_EN
        // One unit per cycle into the current slot unless it is already full
        // (a skip cycle); the pointer always advances round-robin.
        if (rem_q != '0 && parts_q[idx_q] != '1) begin
          parts_d[idx_q] = parts_q[idx_q] + 1'b1;
          rem_d          = rem_q - 1'b1;
        end
        idx_d = (idx_q == LAST_IX) ? '0 : idx_q + 1'b1;
        for (int unsigned i = 0; i < NADDENDS; i++) begin
          if (parts_d[i] != '1) all_full = 1'b0;
        end
        fill_exit = (rem_d == '0) || all_full;
`else
        take           = (rem_q > MAX_T) ? MAX_T[NBITS-1:0] : rem_q[NBITS-1:0];
        parts_d[idx_q] = take;
        rem_d          = rem_q - TBITS'(take);
        idx_d          = idx_q + 1'b1;
        fill_exit      = (rem_d == '0) || (idx_q == LAST_IX);
`endif
        // Overflow is resolved on the way into DONE so it is already valid
        // in the done cycle and then simply holds.
        if (fill_exit) begin
          overflow_d = (rem_d != '0);
          state_d    = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      idx_q      <= '0;
      parts_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      parts_q    <= parts_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.overflow = overflow_q;
  assign bus.parts    = parts_q;

endmodule

// File: tb/tb_logs_split.sv
module tb_logs_split;

  localparam int NB = 3;
  localparam int NA = 6;
  localparam int TB = 6;
  localparam int PW = NB * NA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logs_split_if #(.NBITS(NB), .NADDENDS(NA), .TBITS(TB)) bus ();

  logs_split #(.NBITS(NB), .NADDENDS(NA), .TBITS(TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [TB-1:0] total;
    logic [PW-1:0] exp_parts;
    int            exp_cyc;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drives start for one edge; cyc counts edges from the accepting edge (=1)
  // to the edge after which done is seen.
  task automatic run_op(input logic [TB-1:0] t, output int cyc);
    @(negedge clk);
    bus.start = 1'b1;
    bus.total = t;
    @(posedge clk);
    cyc = 1;
    #1;
    bus.start = 1'b0;
    while (!bus.done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
  endtask

  int            cyc;
  logic          saw_done;
  logic [PW-1:0] r17, r9;
  int            c17;

  initial begin
`ifdef LOGS_SPLIT_EVEN_EN
    vecs[0] = '{6'd8,  {3'd1,3'd1,3'd1,3'd1,3'd2,3'd2}, 9,  1'b0};
    vecs[1] = '{6'd17, {3'd2,3'd3,3'd3,3'd3,3'd3,3'd3}, 18, 1'b0};
    vecs[2] = '{6'd42, {6{3'd7}},                       43, 1'b0};
    vecs[3] = '{6'd0,  '0,                              2,  1'b0};
    vecs[4] = '{6'd50, {6{3'd7}},                       43, 1'b1};
    vecs[5] = '{6'd5,  {3'd0,3'd1,3'd1,3'd1,3'd1,3'd1}, 6,  1'b0};
    vecs[6] = '{6'd9,  {3'd1,3'd1,3'd1,3'd2,3'd2,3'd2}, 10, 1'b0};
    vecs[7] = '{6'd7,  {3'd1,3'd1,3'd1,3'd1,3'd1,3'd2}, 8,  1'b0};
    r17 = {3'd2,3'd3,3'd3,3'd3,3'd3,3'd3};
    c17 = 18;
    r9  = {3'd1,3'd1,3'd1,3'd2,3'd2,3'd2};
`else
    vecs[0] = '{6'd17, {3'd0,3'd0,3'd0,3'd3,3'd7,3'd7}, 4, 1'b0};
    vecs[1] = '{6'd42, {6{3'd7}},                       7, 1'b0};
    vecs[2] = '{6'd0,  '0,                              2, 1'b0};
    vecs[3] = '{6'd50, {6{3'd7}},                       7, 1'b1};
    vecs[4] = '{6'd5,  {3'd0,3'd0,3'd0,3'd0,3'd0,3'd5}, 2, 1'b0};
    vecs[5] = '{6'd9,  {3'd0,3'd0,3'd0,3'd0,3'd2,3'd7}, 3, 1'b0};
    vecs[6] = '{6'd14, {3'd0,3'd0,3'd0,3'd0,3'd7,3'd7}, 3, 1'b0};
    vecs[7] = '{6'd7,  {3'd0,3'd0,3'd0,3'd0,3'd0,3'd7}, 2, 1'b0};
    r17 = {3'd0,3'd0,3'd0,3'd3,3'd7,3'd7};
    c17 = 4;
    r9  = {3'd0,3'd0,3'd0,3'd0,3'd2,3'd7};
`endif

    bus.start = 1'b0;
    bus.total = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_parts", 32'(bus.parts), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].total, cyc);
      check($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      check($sformatf("v%0d_parts", i), 32'(bus.parts), 32'(vecs[i].exp_parts));
      check($sformatf("v%0d_ovf", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("v%0d_busy_at_done", i), 32'(bus.busy), 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), 32'(bus.done), 32'd0);
      check($sformatf("v%0d_busy_after", i), 32'(bus.busy), 32'd0);
      if (i == 3) begin
        repeat (3) @(posedge clk);
        #1;
        check("hold_parts", 32'(bus.parts), 32'(vecs[i].exp_parts));
        check("hold_ovf", 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      end
    end

    // start pulsed while busy must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.total = 6'd17;
    @(posedge clk);
    cyc = 1;
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    cyc++;
    #1;
    bus.start = 1'b1;
    bus.total = 6'd9;
    @(posedge clk);
    cyc++;
    #1;
    bus.start = 1'b0;
    while (!bus.done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    check("busy_start_latency", 32'(cyc), 32'(c17));
    check("busy_start_parts", 32'(bus.parts), 32'(r17));

    // start during the done cycle must be ignored as well
    @(posedge clk);
    #1;
    run_op(6'd9, cyc);
    check("done_start_setup", 32'(bus.parts), 32'(r9));
    bus.start = 1'b1;
    bus.total = 6'd20;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("done_start_busy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;
    check("done_start_busy2", 32'(bus.busy), 32'd0);
    check("done_start_parts", 32'(bus.parts), 32'(r9));

    // reset in the middle of FILL abandons the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.total = 6'd30;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_parts", 32'(bus.parts), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);

    // recovery after reset
    run_op(6'd5, cyc);
    check("recover_parts", 32'(bus.parts[0]), 32'd5);
    check("recover_ovf", 32'(bus.overflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
